// File: rtl/branch_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_pc_unit: PC owner, next-PC select and one-in-flight fetch FSM  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             ex_done,
  input  logic [2:0]       branch,
  input  logic             less,
  input  logic             zero,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_rs1,
  output logic [31:0]      pc,
  output logic [31:0]      link,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_TRAP  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [CNT_W-1:0] r_instret;

  logic [31:0] w_pc_seq;
  logic [31:0] w_pc_tgt;
  logic [31:0] w_jalr_sum;
  logic [31:0] w_jalr_tgt;
  logic [31:0] w_next_pc;
  logic        w_misaligned;
  logic        w_retire;

  assign w_pc_seq   = r_pc + 32'd4;
  assign w_pc_tgt   = r_pc + ex_imm;
  assign w_jalr_sum = ex_rs1 + ex_imm;
  assign w_jalr_tgt = w_jalr_sum & ~32'd1;

  always_comb begin
    w_next_pc = w_pc_seq;
    case (branch)
      3'b001:  w_next_pc = w_pc_tgt;
      3'b010:  w_next_pc = w_jalr_tgt;
      3'b100:  w_next_pc = zero  ? w_pc_tgt : w_pc_seq;
      3'b101:  w_next_pc = !zero ? w_pc_tgt : w_pc_seq;
      3'b110:  w_next_pc = less  ? w_pc_tgt : w_pc_seq;
      3'b111:  w_next_pc = !less ? w_pc_tgt : w_pc_seq;
      default: w_next_pc = w_pc_seq;
    endcase
  end

  // Alignment is judged on the selected target, so untaken branches never trap.
  assign w_misaligned = |w_next_pc[1:0];
  assign w_retire     = (r_state == S_EXEC) && ex_done && !w_misaligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: if (imem_ack) w_state_nxt = S_EXEC;
      S_EXEC:  if (ex_done)  w_state_nxt = w_misaligned ? S_TRAP : S_FETCH;
      S_TRAP:  w_state_nxt = S_TRAP;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    trap        = 1'b0;
    case (r_state)
      S_FETCH: imem_req    = 1'b1;
      S_EXEC:  instr_valid = 1'b1;
      S_TRAP:  trap        = 1'b1;
      default: imem_req    = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_instr   <= 32'd0;
      r_instret <= '0;
    end else begin
      if ((r_state == S_FETCH) && imem_ack) begin
        r_instr <= imem_rdata;
      end
      if (w_retire) begin
        r_pc      <= w_next_pc;
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign link      = w_pc_seq;
  assign instr     = r_instr;
  assign instret   = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_branch_pc_unit.sv
`default_nettype none
// Scoreboard bench for branch_pc_unit: driver pushes expected fetch/trap
// observations, an independent negedge monitor pops and compares them.
module tb_branch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          CNT_W  = 4;

  logic             clk;
  logic             rst;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic [31:0]      instr;
  logic             instr_valid;
  logic             ex_done;
  logic [2:0]       branch;
  logic             less;
  logic             zero;
  logic [31:0]      ex_imm;
  logic [31:0]      ex_rs1;
  logic [31:0]      pc;
  logic [31:0]      link;
  logic             trap;
  logic [CNT_W-1:0] instret;

  branch_pc_unit #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .ex_done(ex_done), .branch(branch),
    .less(less), .zero(zero), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .pc(pc), .link(link), .trap(trap), .instret(instret)
  );

  typedef struct {
    logic [31:0]      addr;
    logic [CNT_W-1:0] ret;
    bit               is_trap;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;
  int unsigned m_ret;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [2:0] br, input logic l, input logic z,
                                          input logic [31:0] imm, input logic [31:0] rs1,
                                          input logic [31:0] cur);
    logic taken;
    case (br)
      3'b001:  return cur + imm;
      3'b010:  return (rs1 + imm) & 32'hFFFF_FFFE;
      3'b100:  taken = z;
      3'b101:  taken = !z;
      3'b110:  taken = l;
      3'b111:  taken = !l;
      default: taken = 1'b0;
    endcase
    return taken ? cur + imm : cur + 32'd4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch();
    exp_t e;
    e.addr = m_pc; e.ret = CNT_W'(m_ret); e.is_trap = 1'b0;
    q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1; ex_done = 1'b0;
    imem_ack = 1'b1; imem_rdata = $urandom;
    tick(); tick();
    rst = 1'b0; imem_ack = 1'b0;
    chk("rst_pc", pc, RST_PC);
    chk("rst_instret", 32'(instret), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_queue_drained", q.size(), 32'd0);
    q.delete();
    m_pc = RST_PC; m_ret = 0;
    push_fetch();
  endtask

  task automatic run_instr(input logic [2:0] br, input logic l, input logic z,
                           input logic [31:0] imm, input logic [31:0] rs1,
                           input int ack_dly, input int done_dly, input bit ack_in_exec);
    logic [31:0] word;
    logic [31:0] nxt;
    exp_t        e;
    for (int i = 0; i < ack_dly; i++) begin
      ex_done = 1'($urandom); branch = 3'($urandom);
      tick();
    end
    ex_done = 1'b0;
    if (ack_dly > 0) begin
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, m_pc);
    end
    word = $urandom; imem_rdata = word; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("cap_instr", instr, word);
    chk("cap_valid", {31'd0, instr_valid}, 32'd1);
    if (ack_in_exec) begin
      imem_ack = 1'b1; imem_rdata = ~word;
      tick();
      imem_ack = 1'b0;
      chk("exec_ack_ignored", instr, word);
    end
    for (int i = 0; i < done_dly; i++) tick();
    branch = br; less = l; zero = z; ex_imm = imm; ex_rs1 = rs1; ex_done = 1'b1;
    nxt = ref_next(br, l, z, imm, rs1, m_pc);
    if (nxt[1:0] != 2'b00) begin
      e.addr = m_pc; e.ret = CNT_W'(m_ret); e.is_trap = 1'b1;
      q.push_back(e);
    end else begin
      m_pc = nxt; m_ret++;
      push_fetch();
    end
    tick();
    ex_done = 1'b0;
    if (nxt[1:0] != 2'b00) begin
      tick(); tick(); tick();
      chk("trap_sticky", {31'd0, trap}, 32'd1);
      chk("trap_pc_hold", pc, m_pc);
      do_reset();
    end
  endtask

  // Monitor: one expected entry per accepted fetch or per trap entry.
  initial begin
    bit   prev_trap = 1'b0;
    bit   fetch_ev;
    bit   trap_ev;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_trap = 1'b0;
      end else begin
        fetch_ev  = imem_req && imem_ack;
        trap_ev   = trap && !prev_trap;
        prev_trap = trap;
        if (fetch_ev || trap_ev) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got fetch=%0d trap=%0d expected none", fetch_ev, trap_ev);
          end else begin
            e = q.pop_front();
            chk("out_kind", {31'd0, trap_ev}, {31'd0, e.is_trap});
            chk("out_pc", pc, e.addr);
            chk("out_instret", 32'(instret), 32'(e.ret));
            if (e.is_trap) begin
              chk("trap_req", {31'd0, imem_req}, 32'd0);
              chk("trap_valid", {31'd0, instr_valid}, 32'd0);
            end else begin
              chk("fetch_addr", imem_addr, e.addr);
              chk("fetch_link", link, e.addr + 32'd4);
              chk("fetch_trap", {31'd0, trap}, 32'd0);
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] w;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; ex_done = 1'b0;
    branch = '0; less = 1'b0; zero = 1'b0; ex_imm = '0; ex_rs1 = '0;
    m_pc = RST_PC; m_ret = 0;
    do_reset();

    for (int i = 0; i < 3; i++) run_instr(3'b000, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    run_instr(3'b010, 0, 0, 32'h0, 32'h200, 0, 0, 0);
    run_instr(3'b100, 0, 1, 32'hFFFF_FFF8, 32'h0, 0, 0, 0);
    run_instr(3'b010, 0, 0, 32'h0, 32'h200, 0, 0, 0);
    run_instr(3'b100, 0, 0, 32'hFFFF_FFF8, 32'h0, 0, 0, 0);
    run_instr(3'b010, 0, 0, 32'h0, 32'h200, 0, 0, 0);
    run_instr(3'b110, 1, 0, 32'd16, 32'h0, 1, 1, 0);
    run_instr(3'b010, 0, 0, 32'd4, 32'h1001, 5, 0, 1);
    run_instr(3'b011, 1, 1, 32'd64, 32'h0, 0, 0, 0);
    run_instr(3'b010, 0, 0, 32'd0, 32'h1002, 0, 0, 0);
    run_instr(3'b101, 0, 1, 32'd6, 32'h0, 0, 0, 0);
    run_instr(3'b010, 0, 0, 32'd0, 32'hFFFF_FFFC, 0, 0, 0);
    run_instr(3'b000, 0, 0, 32'd0, 32'h0, 0, 0, 0);

    // Reset collides with ex_done of a taken jump.
    w = $urandom; imem_rdata = w; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    branch = 3'b001; ex_imm = 32'd8; ex_done = 1'b1; rst = 1'b1;
    tick();
    chk("rst_exec_pc", pc, RST_PC);
    chk("rst_exec_instret", 32'(instret), 32'd0);
    chk("rst_exec_valid", {31'd0, instr_valid}, 32'd0);
    ex_done = 1'b0;
    do_reset();

    for (int i = 0; i < 17; i++) run_instr(3'b000, 0, 0, 32'h0, 32'h0, 0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) imm = $urandom;
      else imm = 32'((int'($urandom_range(0, 64)) - 32) * 4);
      if ($urandom_range(0, 7) == 0) rs1 = $urandom;
      else rs1 = $urandom & 32'hFFFF_FFFC;
      run_instr(3'($urandom), 1'($urandom), 1'($urandom), imm, rs1,
                $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0));
    end

    imem_ack = 1'b1; imem_rdata = $urandom;
    tick();
    imem_ack = 1'b0;
    tick();
    chk("final_queue_drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Fetch-sequencing stage of the single-issue RV32I core, directly downstream of the ALU.
- Consumes the ALU `less`/`zero` flags together with the decoded branch type.
- Owns the PC register and decides the next PC.
- Drives the instruction-memory request handshake and tracks one instruction in flight: fetch, then execute, then PC update.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address (equals pc)
imem_ack  input  1  fetch data valid this cycle
imem_rdata  input  32  fetched instruction word
instr  output  32  captured instruction for decode
instr_valid  output  1  instr is held and awaiting execution
ex_done  input  1  execute stage finished current instr; sampled only in EXEC
branch  input  3  branch type, see Behaviour
less  input  1  ALU less flag
zero  input  1  ALU zero flag (1 = operands equal)
ex_imm  input  32  sign-extended immediate
ex_rs1  input  32  rs1 value (JALR base)
pc  output  32  current PC
link  output  32  pc+4, return address for JAL/JALR writeback
trap  output  1  misaligned branch/jump target detected, sticky
instret  output  CNT_W  retired-instruction count

Behaviour:
- Synchronous reset, active-high:
  - pc=RESET_PC, state=FETCH, instr=0.
  - instr_valid=0, trap=0, instret=0.
  - imem_req=1 from the first cycle after reset deasserts.
- Reset mid-operation wins over every other event in the same cycle. An ack arriving with rst is discarded.
- States:
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, instr_valid<=1, go to EXEC. Without ack, stay and hold the address stable.
  - EXEC: imem_req=0, instr_valid=1. imem_ack is ignored. On ex_done: compute next_pc; if next_pc[1:0]!=0 go to TRAP, else pc<=next_pc, instret<=instret+1, instr_valid<=0, go to FETCH.
  - TRAP: trap=1, imem_req=0, instr_valid=0. pc holds the faulting instruction's PC. instret is not incremented. Only rst exits.
- Branch encoding and next_pc:
  - 000 sequential: pc+4
  - 001 JAL: pc+ex_imm
  - 010 JALR: (ex_rs1+ex_imm) with bit0 cleared
  - 100 BEQ: zero ? pc+ex_imm : pc+4
  - 101 BNE: !zero ? pc+ex_imm : pc+4
  - 110 BLT/BLTU: less ? pc+ex_imm : pc+4
  - 111 BGE/BGEU: !less ? pc+ex_imm : pc+4
  - 011 is reserved and treated as 000.
- Arithmetic: all additions are 32-bit modulo with no overflow detection. pc+4 at 32'hFFFF_FFFC wraps to 0 with no trap.
- link=pc+4, combinational from pc and valid in every state.
- The alignment check applies after JALR bit0 clearing. An untaken branch with a misaligned offset does not trap.
- instret wraps from all-ones to 0.
- Latency: minimum 2 cycles per instruction (ack in the first FETCH cycle, ex_done in the first EXEC cycle). The new pc is visible the cycle after ex_done.
- ex_done outside EXEC has no effect.

Test Plan:
- Reset with RESET_PC=32'h100, ack every FETCH cycle, branch=000, ex_done each EXEC cycle -> imem_addr sequence 100,104,108; instret=3 after 3 instructions; link=pc+4.
- pc=32'h200, branch=100 with zero=1, ex_imm=-8 -> next pc=1F8. Repeat with zero=0 -> 204. BLT with less=1, ex_imm=16 -> 210.
- JALR ex_rs1=32'h1001, ex_imm=4 -> pc=1004, no trap. ex_rs1=32'h1002, ex_imm=0 -> TRAP: trap=1, imem_req=0, pc unchanged, instret unchanged.
- imem_ack withheld 5 cycles -> imem_req stays high and imem_addr stable. An ack pulse in EXEC -> no change to instr.
- rst asserted in EXEC in the same cycle as ex_done -> pc=RESET_PC, instret=0, instr_valid=0 next cycle. rst in TRAP -> trap cleared.
- pc=32'hFFFF_FFFC, branch=000 -> pc=0, no trap. instret preset near all-ones wraps to 0.
